// File: rtl/baud_tick_ctrl.sv
// baud_tick_ctrl -- 16x oversampling baud tick source for the UART.
//
// Owns the divider counter, the active divisor and a one-entry shadow
// divisor. A divisor offered while running is parked in the shadow and
// takes effect on the next tick boundary, so no tick period is ever cut
// short or stretched by a mid-period update.
//
// Optional feature: define AUTOBAUD_EN to add autobaud measurement. The
// divisor is then derived from the length of a low pulse on i_rx.
//
// Parameters
//   NB_CONTA       divider / divisor width in bits
//   DEFAULT_LIMITE divisor loaded at reset (tick period in clock cycles)
//
// Ports
//   i_clock      system clock, rising edge
//   i_reset      asynchronous active-high reset
//   i_enable     1 = run divider, 0 = stop
//   i_cfg_valid  new divisor offered
//   i_cfg_limit  offered divisor (values below 2 are stored as 2)
//   o_cfg_ready  divisor can be accepted this cycle
//   o_limit      active divisor
//   o_pending    shadow divisor waiting for a tick boundary
//   o_tick       1-cycle 16x oversampling tick
//   o_bit_tick   1-cycle pulse on every 16th o_tick
//   i_rx         UART RX line (autobaud only)
//   i_ab_start   start autobaud measurement (pulse, autobaud only)
//   o_ab_done    autobaud success pulse
//   o_ab_error   autobaud failure pulse
module baud_tick_ctrl #(
   parameter int unsigned NB_CONTA       = 16,
   parameter int unsigned DEFAULT_LIMITE = 163
) (
   input  logic                i_clock,
   input  logic                i_reset,
   input  logic                i_enable,
   input  logic                i_cfg_valid,
   input  logic [NB_CONTA-1:0] i_cfg_limit,
   output logic                o_cfg_ready,
   output logic [NB_CONTA-1:0] o_limit,
   output logic                o_pending,
   output logic                o_tick,
   output logic                o_bit_tick,
   input  logic                i_rx,
   input  logic                i_ab_start,
   output logic                o_ab_done,
   output logic                o_ab_error
);

   localparam logic [NB_CONTA-1:0] RST_LIMIT = NB_CONTA'(DEFAULT_LIMITE);
   localparam logic [NB_CONTA-1:0] MIN_LIMIT = NB_CONTA'(2);
   localparam logic [NB_CONTA-1:0] ONE       = NB_CONTA'(1);

   typedef enum logic [1:0] {
      ST_STOP    = 2'd0,
      ST_RUN     = 2'd1
`ifdef AUTOBAUD_EN
      ,
      ST_AB_FALL = 2'd2,
      ST_AB_MEAS = 2'd3
`endif
   } state_t;

   state_t              state;
   state_t              state_next;
   logic [NB_CONTA-1:0] conta;
   logic [NB_CONTA-1:0] shadow;
   logic [NB_CONTA-1:0] cfg_value;
   logic [3:0]          sub;
   logic                xfer;

   assign xfer      = i_cfg_valid & o_cfg_ready;
   assign cfg_value = (i_cfg_limit < MIN_LIMIT) ? MIN_LIMIT : i_cfg_limit;

`ifdef AUTOBAUD_EN
   localparam int unsigned NB_MEAS = NB_CONTA + 4;

   logic               rx_s1;
   logic               rx_s2;
   logic [NB_MEAS-1:0] meas;
   logic [NB_CONTA-1:0] ab_limit;
   logic               ab_fall;
   logic               meas_sat;
   logic               ab_ok;

   // Line idles high, so the synchroniser resets to 1.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         rx_s1 <= 1'b1;
         rx_s2 <= 1'b1;
      end else begin
         rx_s1 <= i_rx;
         rx_s2 <= rx_s1;
      end
   end

   // Fall is seen one cycle early (s2 still high, s1 low) so that every
   // cycle the synced line spends low is counted in AB_MEAS.
   assign ab_fall  = rx_s2 & ~rx_s1;
   assign meas_sat = &meas;
   assign ab_limit = meas[NB_MEAS-1:4];
   assign ab_ok    = (ab_limit >= MIN_LIMIT) & ~meas_sat;

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         meas <= '0;
      end else if (state == ST_AB_FALL && ab_fall) begin
         meas <= '0;
      end else if (state == ST_AB_MEAS && !rx_s2 && !meas_sat) begin
         meas <= meas + NB_MEAS'(1);
      end
   end
`else
   logic unused_ab;
   assign unused_ab = ^{i_rx, i_ab_start};
`endif

   // State register
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         state <= ST_STOP;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         ST_STOP: begin
`ifdef AUTOBAUD_EN
            if (i_ab_start) begin
               state_next = ST_AB_FALL;
            end else
`endif
            if (i_enable) begin
               state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            if (!i_enable) begin
               state_next = ST_STOP;
            end
         end
`ifdef AUTOBAUD_EN
         ST_AB_FALL: begin
            if (ab_fall) begin
               state_next = ST_AB_MEAS;
            end
         end
         ST_AB_MEAS: begin
            if (rx_s2) begin
               state_next = ST_STOP;
            end
         end
`endif
         default: state_next = ST_STOP;
      endcase
   end

   // Output logic
   always_comb begin
      o_cfg_ready = 1'b0;
      o_tick      = 1'b0;
      o_bit_tick  = 1'b0;
      o_ab_done   = 1'b0;
      o_ab_error  = 1'b0;
      case (state)
         ST_STOP: begin
            o_cfg_ready = ~o_pending;
         end
         ST_RUN: begin
            o_cfg_ready = ~o_pending;
            o_tick      = (conta == o_limit);
            o_bit_tick  = o_tick & (sub == 4'hF);
         end
`ifdef AUTOBAUD_EN
         ST_AB_MEAS: begin
            if (rx_s2) begin
               o_ab_done  = ab_ok;
               o_ab_error = ~ab_ok;
            end
         end
`endif
         default: ;
      endcase
   end

   // Divider, sub-counter and divisor registers
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         conta     <= '0;
         sub       <= '0;
         o_limit   <= RST_LIMIT;
         shadow    <= '0;
         o_pending <= 1'b0;
      end else begin
         case (state)
            ST_STOP: begin
               conta <= '0;
               sub   <= '0;
               if (xfer) begin
                  o_limit <= cfg_value;
               end
            end
            ST_RUN: begin
               if (!i_enable) begin
                  // Stop edge: flush any parked divisor; a divisor offered
                  // on this very edge goes straight to o_limit so nothing
                  // is left pending in STOP.
                  conta     <= '0;
                  sub       <= '0;
                  o_pending <= 1'b0;
                  if (xfer) begin
                     o_limit <= cfg_value;
                  end else if (o_pending) begin
                     o_limit <= shadow;
                  end
               end else begin
                  if (o_tick) begin
                     conta <= ONE;
                     sub   <= sub + 4'd1;
                     if (o_pending) begin
                        o_limit   <= shadow;
                        o_pending <= 1'b0;
                     end
                  end else begin
                     conta <= conta + ONE;
                  end
                  // xfer implies the shadow was empty, so this never
                  // collides with the shadow apply above.
                  if (xfer) begin
                     shadow    <= cfg_value;
                     o_pending <= 1'b1;
                  end
               end
            end
`ifdef AUTOBAUD_EN
            ST_AB_MEAS: begin
               conta <= '0;
               sub   <= '0;
               if (o_ab_done) begin
                  o_limit <= ab_limit;
               end
            end
`endif
            default: begin
               conta <= '0;
               sub   <= '0;
            end
         endcase
      end
   end

endmodule
